// File: rtl/isp_color_adjust.sv
// RGB565 -> RGB888 colour stage: per-channel gain, signed offset and clamp, with settings
// shadowed at frame start and a per-frame clipped-pixel counter. Fixed 3-clock latency.
module isp_color_adjust #(
  parameter bit          VS_POL = 1'b1,
  parameter int unsigned CLIP_W = 20
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              i_vs,
  input  logic              i_hs,
  input  logic              i_de,
  input  logic [15:0]       i_rgb565,
  input  logic [4:0]        i_gain_r,
  input  logic [4:0]        i_gain_g,
  input  logic [4:0]        i_gain_b,
  input  logic [8:0]        i_off_r,
  input  logic [8:0]        i_off_g,
  input  logic [8:0]        i_off_b,
  input  logic              i_bypass,
  output logic              o_vs,
  output logic              o_hs,
  output logic              o_de,
  output logic [7:0]        o_r,
  output logic [7:0]        o_g,
  output logic [7:0]        o_b,
  output logic [CLIP_W-1:0] o_clip_cnt
);

  localparam logic [CLIP_W-1:0] ClipMax = {CLIP_W{1'b1}};

  // Channel index 0 = R, 1 = G, 2 = B throughout.
  logic            vs_d;
  logic            frame_start;
  logic [2:0][4:0] gain_act, gain_cur;
  logic [2:0][8:0] off_act, off_cur;
  logic            byp_act, byp_cur;
  logic [2:0][7:0] c8;

  logic            s1_de, s1_vs, s1_hs, s1_byp;
  logic [2:0][7:0] s1_c;
  logic [2:0][4:0] s1_gain;
  logic [2:0][8:0] s1_off;

  logic            s2_de, s2_vs, s2_hs;
  logic [2:0][8:0] s2_p, p_d;
  logic [2:0][8:0] s2_off;

  logic [2:0][10:0] sum;
  logic [2:0][7:0]  res;
  logic [2:0]       clamped;
  logic             clip_inc;
  logic [CLIP_W-1:0] clip_run_q, clip_sum;

  assign frame_start = (vs_d != VS_POL) && (i_vs == VS_POL);

  // A pixel in the frame-start cycle must already see the new settings, so bypass the shadow.
  assign gain_cur = frame_start ? {i_gain_b, i_gain_g, i_gain_r} : gain_act;
  assign off_cur  = frame_start ? {i_off_b, i_off_g, i_off_r} : off_act;
  assign byp_cur  = frame_start ? i_bypass : byp_act;

  assign c8[0] = {i_rgb565[15:11], i_rgb565[15:13]};
  assign c8[1] = {i_rgb565[10:5],  i_rgb565[10:9]};
  assign c8[2] = {i_rgb565[4:0],   i_rgb565[4:2]};

  always_ff @(posedge clk) begin
    if (!rstn) begin
      vs_d     <= 1'b0;
      gain_act <= {3{5'd16}};
      off_act  <= '0;
      byp_act  <= 1'b0;
    end else begin
      vs_d     <= i_vs;
      gain_act <= gain_cur;
      off_act  <= off_cur;
      byp_act  <= byp_cur;
    end
  end

  // Settings travel with the pixel so in-flight pixels are unaffected by a frame start.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      s1_de   <= 1'b0;
      s1_vs   <= 1'b0;
      s1_hs   <= 1'b0;
      s1_byp  <= 1'b0;
      s1_c    <= '0;
      s1_gain <= '0;
      s1_off  <= '0;
    end else begin
      s1_de   <= i_de;
      s1_vs   <= i_vs;
      s1_hs   <= i_hs;
      s1_byp  <= byp_cur;
      s1_c    <= c8;
      s1_gain <= gain_cur;
      s1_off  <= off_cur;
    end
  end

  always_comb begin
    p_d = '0;
    for (int ch = 0; ch < 3; ch++) begin
      p_d[ch] = s1_byp ? {1'b0, s1_c[ch]}
                       : 9'((13'(s1_c[ch]) * 13'(s1_gain[ch])) >> 4);
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      s2_de  <= 1'b0;
      s2_vs  <= 1'b0;
      s2_hs  <= 1'b0;
      s2_p   <= '0;
      s2_off <= '0;
    end else begin
      s2_de  <= s1_de;
      s2_vs  <= s1_vs;
      s2_hs  <= s1_hs;
      s2_p   <= p_d;
      s2_off <= s1_byp ? '0 : s1_off;
    end
  end

  always_comb begin
    sum     = '0;
    res     = '0;
    clamped = '0;
    for (int ch = 0; ch < 3; ch++) begin
      sum[ch] = {2'b00, s2_p[ch]} + {{2{s2_off[ch][8]}}, s2_off[ch]};
      if (sum[ch][10]) begin
        res[ch]     = 8'h00;
        clamped[ch] = 1'b1;
      end else if (|sum[ch][9:8]) begin
        res[ch]     = 8'hFF;
        clamped[ch] = 1'b1;
      end else begin
        res[ch]     = sum[ch][7:0];
      end
    end
  end

  assign clip_inc = s2_de & (|clamped);
  // A clip landing on the frame-start cycle still belongs to the frame being closed.
  assign clip_sum = (clip_run_q == ClipMax) ? ClipMax : clip_run_q + CLIP_W'(clip_inc);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      o_vs       <= 1'b0;
      o_hs       <= 1'b0;
      o_de       <= 1'b0;
      o_r        <= 8'h00;
      o_g        <= 8'h00;
      o_b        <= 8'h00;
      clip_run_q <= '0;
      o_clip_cnt <= '0;
    end else begin
      o_vs <= s2_vs;
      o_hs <= s2_hs;
      o_de <= s2_de;
      o_r  <= s2_de ? res[0] : 8'h00;
      o_g  <= s2_de ? res[1] : 8'h00;
      o_b  <= s2_de ? res[2] : 8'h00;
      if (frame_start) begin
        o_clip_cnt <= clip_sum;
        clip_run_q <= '0;
      end else begin
        clip_run_q <= clip_sum;
      end
    end
  end

endmodule
